// File: rtl/mem_wb_skid_reg.sv
// MEM/WB stage register as a two-entry valid/ready skid buffer with writeback-data select and flush.
// Optional forwarding of the head entry to the hazard unit is enabled by defining MEM_WB_SKID_FWD_EN.
module mem_wb_skid_reg #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ram_rdata_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic              mem_to_reg_in,
   input  logic              gp_reg_wb_in,
   input  logic [ADDR_W-1:0] wb_addr_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [ADDR_W-1:0] wb_addr_out,
   output logic              gp_reg_wb_out,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        state;
   logic [DATA_W-1:0] main_data, skid_data;
   logic [ADDR_W-1:0] main_addr, skid_addr;
   logic              main_wb, skid_wb;
   logic [DATA_W-1:0] cap_data;
   logic              accept, pop;

   // Ready and valid are pure state decodes, so out_ready never reaches in_ready combinationally.
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign cap_data  = mem_to_reg_in ? ram_rdata_in : alu_result_in;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_EMPTY;
         main_data <= '0;
         main_addr <= '0;
         main_wb   <= 1'b0;
         skid_data <= '0;
         skid_addr <= '0;
         skid_wb   <= 1'b0;
      end else if (flush) begin
         // Payload is left untouched; only the occupancy is cleared, which also drops any accept.
         state <= ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_data <= cap_data;
                  main_addr <= wb_addr_in;
                  main_wb   <= gp_reg_wb_in;
                  state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  main_data <= cap_data;
                  main_addr <= wb_addr_in;
                  main_wb   <= gp_reg_wb_in;
               end else if (accept) begin
                  skid_data <= cap_data;
                  skid_addr <= wb_addr_in;
                  skid_wb   <= gp_reg_wb_in;
                  state     <= ST_FULL;
               end else if (pop) begin
                  state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  main_data <= skid_data;
                  main_addr <= skid_addr;
                  main_wb   <= skid_wb;
                  state     <= ST_ONE;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign wb_data_out   = main_data;
   assign wb_addr_out   = main_addr;
   assign gp_reg_wb_out = main_wb & out_valid;

`ifdef MEM_WB_SKID_FWD_EN
   // Only the head is forwarded; the younger skid entry becomes visible once promoted.
   assign fwd_valid = out_valid & main_wb;
   assign fwd_addr  = main_addr;
   assign fwd_data  = main_data;
`else
   assign fwd_valid = 1'b0;
   assign fwd_addr  = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM/WB pipeline register for the 10-bit core. It replaces the always-enabled stage register with a two-entry valid/ready skid buffer, so writeback back-pressure never forces a combinational stall path into MEM. It selects the writeback value (RAM read data or ALU result) at capture time and supports a synchronous flush. When configured in, it also exposes the head entry to the hazard unit as a forwarding source.

## Interface
Parameters:
- DATA_W, 10, width of RAM read data, ALU result and stored writeback data
- ADDR_W, 3, width of the general-purpose register destination address

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  block can accept this cycle
- ram_rdata_in  input  DATA_W  RAM read data
- alu_result_in  input  DATA_W  ALU result
- mem_to_reg_in  input  1  1 = write back RAM data, 0 = write back ALU result
- gp_reg_wb_in  input  1  instruction writes a GP register
- wb_addr_in  input  ADDR_W  destination register address
- flush  input  1  discard all held entries
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback consumes head entry
- wb_data_out  output  DATA_W  selected writeback data of head entry
- wb_addr_out  output  ADDR_W  destination address of head entry
- gp_reg_wb_out  output  1  stored write enable AND out_valid
- fwd_valid  output  1  head entry is a valid forwarding source
- fwd_addr  output  ADDR_W  forwarding destination address
- fwd_data  output  DATA_W  forwarding data

## Operation
- Storage is two entries: main (drives the outputs) and skid. Each entry holds {data, addr, wb_en}.
- Captured data is mem_to_reg_in ? ram_rdata_in : alu_result_in. Width is DATA_W with no extension or truncation.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- States: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
  - EMPTY: accept -> ONE, input loaded into main.
  - ONE: accept & pop -> ONE, main reloaded from input. accept & !pop -> FULL, input loaded into skid. pop only -> EMPTY. Neither -> ONE.
  - FULL: pop -> ONE, main <= skid. !pop -> FULL.
- in_ready = (state != FULL). It is a registered-state decode only and has no combinational path from out_ready.
- In FULL, in_valid is ignored; the producer must hold its data.
- out_valid = (state != EMPTY).
- Ordering is strict FIFO: the skid entry always leaves after main.
- flush (while reset is high):
  - Next state is EMPTY.
  - An accept in the same cycle is dropped.
  - A pop in the same cycle still counts; the consumer has taken the head.
  - Entry payload registers keep their values but are invalid.
- reset = 0 at a rising edge:
  - State becomes EMPTY and all payload registers clear to 0.
  - Reset has priority over flush and all handshakes.
  - Reset mid-operation discards both entries.

## Timing
- Latency: accept in cycle N into EMPTY -> out_valid = 1 in cycle N+1, with the data registered.
- Throughput: one entry per cycle when out_ready is held at 1.
- After out_ready deasserts, at most one further entry is accepted (skid). in_ready drops in the cycle after FULL is entered.
- After reset:
  - in_ready = 1.
  - out_valid = 0, gp_reg_wb_out = 0, fwd_valid = 0.
  - wb_data_out = 0, wb_addr_out = 0, fwd_addr = 0, fwd_data = 0.
- All outputs are driven from registers or a state decode. The only combinational output logic is the AND in gp_reg_wb_out and fwd_valid.

## Configuration
- Macro: MEM_WB_SKID_FWD_EN.
- Defined:
  - fwd_valid = out_valid & main.wb_en.
  - fwd_addr and fwd_data mirror the main entry.
  - During FULL, the skid entry is not forwarded; it is younger and is forwarded only once promoted to main.
- Undefined:
  - fwd_valid, fwd_addr and fwd_data are tied to 0.
  - The ports remain present so the hazard-unit wiring does not change.

## Test plan
- Reset and first capture: hold reset = 0 for 2 cycles -> in_ready = 1, out_valid = 0, all data outputs 0. Release reset, accept alu_result_in = 0x155, mem_to_reg_in = 0, wb_addr_in = 5, gp_reg_wb_in = 1 -> next cycle out_valid = 1, wb_data_out = 0x155, wb_addr_out = 5, gp_reg_wb_out = 1.
- Mux select: accept ram_rdata_in = 0x3FF with alu_result_in = 0x001 and mem_to_reg_in = 1 -> wb_data_out = 0x3FF.
- Back-pressure: out_ready = 0, stream A = 0x010 then B = 0x020 -> FULL, in_ready = 0, C is held off. Raise out_ready -> outputs A, B, C in order, with no loss and no duplicate.
- Full streaming: out_ready = 1, in_valid = 1 for 8 cycles with data 1..8 -> out_valid stays 1 from cycle 2 and wb_data_out steps 1..8 one per cycle. in_ready never drops.
- Flush: in FULL, assert flush together with in_valid = 1 -> next cycle out_valid = 0 and in_ready = 1, and the flushed-cycle input never appears. Repeat with reset = 0 and flush = 1 together -> EMPTY with payload registers cleared.
- Forwarding: with MEM_WB_SKID_FWD_EN defined, head {addr 3, data 0x0AA, wb_en 1} -> fwd_valid = 1, fwd_addr = 3, fwd_data = 0x0AA. With wb_en = 0 -> fwd_valid = 0. With the macro undefined -> all three forwarding outputs are 0.
